// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction memory read port and
// the instruction stream towards the decoder.
// master = fetch unit side, slave = environment (memory/consumer/PC) side.
interface fetch_unit_if;
   logic [15:0] pc_in;
   logic        pc_wr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      input  pc_in, pc_wr, mem_ack, mem_rdata, instr_ready,
      output mem_req, mem_addr, instr, instr_pc, instr_valid
   );

   modport slave (
      output pc_in, pc_wr, mem_ack, mem_rdata, instr_ready,
      input  mem_req, mem_addr, instr, instr_pc, instr_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// buffers up to two {pc, instr} entries and hands them to the consumer.
// A redirect (pc_wr) flushes the buffer and restarts fetching at pc_in; a
// read already in flight is drained and its data dropped.
// Optional feature macro: FETCH_STALL_CNT_EN adds a 16-bit saturating
// stall_cnt output (cycles where the consumer is ready but nothing is valid).
module fetch_unit (
   input  logic         clk,
   input  logic         rst_n,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]  stall_cnt,
`endif
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_FULL  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] fetch_addr_q, fetch_addr_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] pc0_q, pc0_d, ins0_q, ins0_d;
   logic [15:0] pc1_q, pc1_d, ins1_q, ins1_d;
   logic        valid_q, valid_d;
   logic        mem_req_q, mem_req_d;
   logic [15:0] mem_addr_q, mem_addr_d;

   logic        ack_s;
   logic        pop_s;
   logic        push_s;

   // An ack only counts while our own request is up; stray acks after reset are dropped.
   assign ack_s  = bus.mem_ack & mem_req_q;
   assign pop_s  = valid_q & bus.instr_ready;
   assign push_s = (state_q == S_REQ) & ack_s & ~bus.pc_wr;

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr       = ins0_q;
   assign bus.instr_pc    = pc0_q;
   assign bus.instr_valid = valid_q;

   // Two-entry FIFO update: entry 0 is always the head; redirect flushes.
   always_comb begin
      count_d = count_q;
      pc0_d   = pc0_q;
      ins0_d  = ins0_q;
      pc1_d   = pc1_q;
      ins1_d  = ins1_q;
      if (bus.pc_wr) begin
         count_d = 2'd0;
      end else if (push_s && pop_s) begin
         if (count_q == 2'd1) begin
            pc0_d  = mem_addr_q;
            ins0_d = bus.mem_rdata;
         end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = mem_addr_q;
            ins1_d = bus.mem_rdata;
         end
      end else if (push_s) begin
         if (count_q == 2'd0) begin
            pc0_d  = mem_addr_q;
            ins0_d = bus.mem_rdata;
         end else begin
            pc1_d  = mem_addr_q;
            ins1_d = bus.mem_rdata;
         end
         count_d = count_q + 2'd1;
      end else if (pop_s) begin
         pc0_d   = pc1_q;
         ins0_d  = ins1_q;
         count_d = count_q - 2'd1;
      end else begin
         count_d = count_q;
      end
      valid_d = (count_d != 2'd0);
   end

   // Fetch FSM next state, fetch address and registered memory request outputs.
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      case (state_q)
         S_REQ: begin
            if (bus.pc_wr) begin
               fetch_addr_d = bus.pc_in;
               if (ack_s) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (ack_s) begin
               fetch_addr_d = fetch_addr_q + 16'd1;
               if (count_d == 2'd2) begin
                  state_d = S_FULL;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               state_d = S_REQ;
            end
         end
         S_FULL: begin
            if (bus.pc_wr) begin
               fetch_addr_d = bus.pc_in;
               state_d      = S_REQ;
            end else if (pop_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_FULL;
            end
         end
         S_DRAIN: begin
            if (bus.pc_wr) begin
               fetch_addr_d = bus.pc_in;
            end else begin
               fetch_addr_d = fetch_addr_q;
            end
            if (ack_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d      = S_REQ;
            fetch_addr_d = fetch_addr_q;
         end
      endcase
      mem_req_d = (state_d != S_FULL);
      // While draining the stale read its address must stay on the bus.
      if (state_d == S_DRAIN) begin
         mem_addr_d = mem_addr_q;
      end else begin
         mem_addr_d = fetch_addr_d;
      end
   end

   // State, FIFO and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         fetch_addr_q <= 16'h0000;
         count_q      <= 2'd0;
         pc0_q        <= 16'h0000;
         ins0_q       <= 16'h0000;
         pc1_q        <= 16'h0000;
         ins1_q       <= 16'h0000;
         valid_q      <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         count_q      <= count_d;
         pc0_q        <= pc0_d;
         ins0_q       <= ins0_d;
         pc1_q        <= pc1_d;
         ins1_q       <= ins1_d;
         valid_q      <= valid_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt = stall_cnt_q;

   // Saturating count of cycles where the consumer waits on an empty buffer.
   always_comb begin
      if (bus.instr_ready && !valid_q && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`else
   // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus thread pushes the expected
// {pc, instr} stream, a memory responder answers requests after a set delay,
// and a monitor pops and compares on every accepted instruction.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;
   fetch_unit_if bus();

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   fetch_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef FETCH_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ins;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   mem_delay = 1;
   int   wcnt      = 0;
   bit   mon_en    = 1'b0;
   bit   chk_rate  = 1'b0;
   bit   have_last = 1'b0;
   int   last_cyc  = 0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
   endtask

   task automatic push_exp(input logic [15:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = mem_word(pc);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else begin
         $display("FAIL %s: %0d entries still outstanding after %0d cycles, required 0", name, sb.size(), n);
         sb.delete();
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: ack mem_delay cycles after a request is first seen.
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (rst_n !== 1'b1) begin
            wcnt = 0;
         end else if (bus.mem_req === 1'b1) begin
            if (wcnt >= mem_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // Monitor: every accepted instruction must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pop: got pc 0x%04h, required no transfer", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               check("instr_pc", bus.instr_pc, e.pc);
               check("instr", bus.instr, e.ins);
               if (chk_rate && have_last) check("pop_gap", 16'(cyc - last_cyc), 16'd2);
               have_last = 1'b1;
               last_cyc  = cyc;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      bus.pc_in       = 16'h0000;
      bus.pc_wr       = 1'b0;
      bus.instr_ready = 1'b0;
      mem_delay       = 1;
      mon_en          = 1'b1;
      repeat (3) step();

      // Reset values
      check("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
      check("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
      check("rst_instr", bus.instr, 16'h0000);
      check("rst_instr_pc", bus.instr_pc, 16'h0000);
      check("rst_mem_addr", bus.mem_addr, 16'h0000);

      // Streaming: one instruction every two cycles from address 0
      chk_rate  = 1'b1;
      have_last = 1'b0;
      for (int i = 0; i < 8; i++) push_exp(16'(i));
      bus.instr_ready = 1'b1;
      rst_n = 1'b1;
      step();
      check("first_req", {15'd0, bus.mem_req}, 16'd1);
      check("first_addr", bus.mem_addr, 16'h0000);
      wait_empty("stream", 40);
      bus.instr_ready = 1'b0;
      chk_rate = 1'b0;

      // Consumer stalled: buffer fills, request drops, then resumes in order
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (10) step();
      check("full_mem_req", {15'd0, bus.mem_req}, 16'd0);
      check("full_valid", {15'd0, bus.instr_valid}, 16'd1);
      check("full_head_pc", bus.instr_pc, 16'h0000);
      for (int i = 0; i < 4; i++) push_exp(16'(i));
      bus.instr_ready = 1'b1;
      wait_empty("full_drain", 40);
      bus.instr_ready = 1'b0;

      // Redirect while a slow read is pending: stale address held, data dropped
      rst_n = 1'b0;
      mem_delay = 3;
      step();
      rst_n = 1'b1;
      bus.instr_ready = 1'b1;
      step();
      step();
      bus.pc_in = 16'h0020;
      bus.pc_wr = 1'b1;
      step();
      bus.pc_wr = 1'b0;
      check("drain_req", {15'd0, bus.mem_req}, 16'd1);
      check("drain_addr", bus.mem_addr, 16'h0000);
      step();
      step();
      check("redir_addr", bus.mem_addr, 16'h0020);
      check("redir_valid", {15'd0, bus.instr_valid}, 16'd0);
      push_exp(16'h0020);
      push_exp(16'h0021);
      wait_empty("redirect", 40);
      bus.instr_ready = 1'b0;

      // Back-to-back redirects, last one wins, and address wraps
      mem_delay = 1;
      repeat (5) step();
      bus.pc_in = 16'h1234;
      bus.pc_wr = 1'b1;
      step();
      bus.pc_in = 16'hFFFF;
      step();
      bus.pc_wr = 1'b0;
      check("flush_valid", {15'd0, bus.instr_valid}, 16'd0);
      push_exp(16'hFFFF);
      push_exp(16'h0000);
      push_exp(16'h0001);
      bus.instr_ready = 1'b1;
      wait_empty("wrap", 40);
      bus.instr_ready = 1'b0;

      // Reset with two entries buffered
      repeat (8) step();
      check("buf_valid", {15'd0, bus.instr_valid}, 16'd1);
      check("buf_mem_req", {15'd0, bus.mem_req}, 16'd0);
      rst_n = 1'b0;
      #1;
      check("arst_valid", {15'd0, bus.instr_valid}, 16'd0);
      check("arst_mem_req", {15'd0, bus.mem_req}, 16'd0);
      check("arst_instr_pc", bus.instr_pc, 16'h0000);
      step();
      rst_n = 1'b1;
      push_exp(16'h0000);
      push_exp(16'h0001);
      bus.instr_ready = 1'b1;
      wait_empty("refetch", 40);
      bus.instr_ready = 1'b0;

`ifdef FETCH_STALL_CNT_EN
      // Slow memory with a ready consumer: 12 empty cycles before the first word
      rst_n = 1'b0;
      mem_delay = 10;
      bus.instr_ready = 1'b1;
      step();
      check("stall_rst", stall_cnt, 16'd0);
      push_exp(16'h0000);
      rst_n = 1'b1;
      repeat (12) step();
      check("stall_cnt", stall_cnt, 16'd12);
      check("stall_valid", {15'd0, bus.instr_valid}, 16'd1);
      wait_empty("stall_pop", 10);
      bus.instr_ready = 1'b0;
`endif

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 pc_in  input  16  redirect target, driven from the program counter's data_out.
REQ-004 pc_wr  input  1  redirect strobe, the same signal as the program counter's write_en; pc_in valid when high.
REQ-005 mem_req  output  1  instruction memory read request; held until mem_ack.
REQ-006 mem_addr  output  16  word address of the request; stable while mem_req high.
REQ-007 mem_ack  input  1  one-cycle completion; mem_rdata valid in the same cycle.
REQ-008 mem_rdata  input  16  instruction word.
REQ-009 instr  output  16  instruction at FIFO head.
REQ-010 instr_pc  output  16  address of instr.
REQ-011 instr_valid  output  1  FIFO head valid.
REQ-012 instr_ready  input  1  consumer accepts; transfer when instr_valid && instr_ready.

Function
REQ-013 Internal fetch_addr, 16 bit; +1 per completed kept fetch; 0xFFFF wraps to 0x0000.
REQ-014 FIFO: 2 entries of {pc, instr}; instr_valid = (count != 0); instr/instr_pc come from the head entry, registered.
REQ-015 FSM states: REQ (mem_req=1, mem_addr=fetch_addr), FULL (mem_req=0), DRAIN (mem_req=1, stale address held).
REQ-016 REQ entry rule: REQ is entered only when count < 2 after this cycle's pop and push.
REQ-017 REQ transitions: on ack, the entry is pushed and the FSM goes to REQ if a slot remains, otherwise to FULL; with no ack it stays in REQ.
REQ-018 FULL to REQ occurs in the cycle after a pop.
REQ-019 Latency: ack in cycle N gives instr_valid=1 in cycle N+1; new mem_req in cycle N+1 if space.
REQ-020 Simultaneous push and pop: count is unchanged and ordering is preserved.
REQ-021 Redirect (pc_wr=1) has priority over every other event: FIFO is flushed (count=0 next cycle) and fetch_addr is set to pc_in.
REQ-022 Redirect in REQ with mem_ack in the same cycle: rdata is discarded and the next state is REQ at pc_in.
REQ-023 Redirect in REQ without mem_ack: the next state is DRAIN, mem_addr holds the old address until ack, the data is discarded, and the next state is REQ at pc_in.
REQ-024 Redirect during DRAIN: only fetch_addr is updated; DRAIN continues.
REQ-025 A pop in a redirect cycle is a completed transfer.
REQ-026 Back-to-back redirects: the last pc_in wins.
REQ-027 Outstanding reads never exceed 1.

Reset
REQ-028 rst_n low asynchronously forces: state=REQ, fetch_addr=0x0000, count=0, instr_valid=0, instr=0x0000, instr_pc=0x0000, mem_addr=0x0000.
REQ-029 mem_req is 0 while rst_n is low; the first request (addr 0x0000) is issued in the first cycle after deassertion.
REQ-030 Reset mid-transfer abandons the outstanding read; a late mem_ack is ignored until the first post-reset request.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN; when defined, a 16-bit output stall_cnt is added.
REQ-032 stall_cnt counts cycles with instr_ready=1 && instr_valid=0, saturates at 0xFFFF, and resets to 0.
REQ-033 Without FETCH_STALL_CNT_EN, the stall_cnt port and its logic are absent and all other behaviour is identical.

Verification
REQ-034 Reset release, memory acks 1 cycle after each req, instr_ready=1 -> addresses 0,1,2,...; instr_pc matches; one instr every 2 cycles.
REQ-035 instr_ready=0, acks supplied -> two entries held, mem_req=0 (FULL); raise instr_ready -> pops in order 0x0000, 0x0001, then fetch resumes at 0x0002.
REQ-036 pc_wr=1, pc_in=0x0020 while a req is pending, ack 3 cycles later -> ack discarded; next mem_addr=0x0020; first instr_pc=0x0020.
REQ-037 pc_in=0xFFFF redirect -> fetches 0xFFFF then 0x0000.
REQ-038 rst_n pulsed low with 2 entries buffered -> instr_valid=0 immediately; refetch from 0x0000.
REQ-039 With FETCH_STALL_CNT_EN, memory withholds ack for 10 cycles, instr_ready=1 -> stall_cnt=10 (plus startup cycles, counted exactly per REQ-032).
